// File: rtl/pin_entry_keypad.sv
// Keypad front end for the parking controller PIN handshake: collects hex digits,
// presents the code with code_ack for a fixed window, and locks out while alarmed.
module pin_entry_keypad #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned ACK_HOLD = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_value,
  input  logic                  key_enter,
  input  logic                  key_clear,
  input  logic                  lockout,
  output logic [4*DIGITS-1:0]   code,
  output logic                  code_ack,
  output logic [2:0]            digit_count,
  output logic                  entry_error
);

  localparam int unsigned CodeW = 4 * DIGITS;
  localparam int unsigned TmoW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned AckW  = $clog2(ACK_HOLD + 1);

  localparam logic [2:0]      FullCount = 3'(DIGITS);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AckW-1:0] AckLimit  = AckW'(ACK_HOLD);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StPresent,
    StRelease,
    StLocked
  } state_e;

  state_e           state;
  logic [CodeW-1:0] shift;
  logic [TmoW-1:0]  tmo_cnt;
  logic [AckW-1:0]  ack_cnt;

  logic             full;
  logic [CodeW-1:0] shift_next;

  assign full       = (digit_count == FullCount);
  assign shift_next = {shift[CodeW-5:0], key_value};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      shift       <= '0;
      tmo_cnt     <= '0;
      ack_cnt     <= '0;
      code        <= '0;
      code_ack    <= 1'b0;
      digit_count <= 3'd0;
      entry_error <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      if (lockout) begin
        // Alarm overrides everything, silently discarding any entry or presentation.
        state       <= StLocked;
        code_ack    <= 1'b0;
        shift       <= '0;
        digit_count <= 3'd0;
        tmo_cnt     <= '0;
        ack_cnt     <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (key_clear) begin
              state <= StIdle;
            end else if (key_enter) begin
              entry_error <= 1'b1;
            end else if (key_valid) begin
              shift       <= shift_next;
              digit_count <= 3'd1;
              tmo_cnt     <= '0;
              state       <= StCollect;
            end
          end

          StCollect: begin
            if (key_clear) begin
              shift       <= '0;
              digit_count <= 3'd0;
              tmo_cnt     <= '0;
              state       <= StIdle;
            end else if (key_enter) begin
              tmo_cnt <= '0;
              if (full) begin
                code     <= shift;
                code_ack <= 1'b1;
                ack_cnt  <= AckW'(1);
                state    <= StPresent;
              end else begin
                entry_error <= 1'b1;
                shift       <= '0;
                digit_count <= 3'd0;
                state       <= StIdle;
              end
            end else if (key_valid && !full) begin
              shift       <= shift_next;
              digit_count <= digit_count + 3'd1;
              tmo_cnt     <= '0;
            end else begin
              // Overflow digits are rejected but do not restart the idle timer.
              if (key_valid) begin
                entry_error <= 1'b1;
              end
              if ((TIMEOUT != 0) && (tmo_cnt == TmoLast)) begin
                entry_error <= 1'b1;
                shift       <= '0;
                digit_count <= 3'd0;
                tmo_cnt     <= '0;
                state       <= StIdle;
              end else if (TIMEOUT != 0) begin
                tmo_cnt <= tmo_cnt + TmoW'(1);
              end
            end
          end

          StPresent: begin
            if (ack_cnt == AckLimit) begin
              code_ack    <= 1'b0;
              ack_cnt     <= '0;
              shift       <= '0;
              digit_count <= 3'd0;
              state       <= StRelease;
            end else begin
              ack_cnt <= ack_cnt + AckW'(1);
            end
          end

          // One guaranteed low cycle so the controller sees code_ack fall.
          StRelease: state <= StIdle;

          StLocked: state <= StIdle;

          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
